decode_execute_reg: RTL and testbench
=====================================

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have ports: valid_d  in  1  decode slot holds a real instruction; pc_d  in  32  decode PC.
REQ-003 SHALL have ports: rs1_data_d, rs2_data_d, imm_d  in  32 each  register-file reads and immediate.
REQ-004 SHALL have ports: rd_d  in  5  destination; rd_valid_d, mem_read_d, mem_write_d  in  1 each  decode controls; alu_op_d  in  4  ALU opcode.
REQ-005 SHALL have ports: fwd_sel  in  4  hazard-unit forward select (bit0 rs1<-M, bit1 rs2<-M, bit2 rs1<-W, bit3 rs2<-W); stall  in  1  load-use stall; flush  in  1  taken branch/jump in execute.
REQ-006 SHALL have ports: alu_res_m  in  32  ALU result in memory stage; reg_d_w  in  32  writeback data.
REQ-007 SHALL have ports: valid_e, rd_valid_e, mem_read_e, mem_write_e  out  1 each; pc_e, imm_e  out  32; rd_e  out  5; alu_op_e  out  4; op_a_e, op_b_e  out  32  forwarded rs1/rs2 operands.
REQ-008 SHALL have ports (macro only): stall_cnt, flush_cnt  out  32  event counters.

Function
REQ-009 SHALL register all decode inputs and fwd_sel into execute-stage registers on each rising clk edge (latency 1 cycle).
REQ-010 SHALL, when flush=1 or stall=1 at an edge, load a bubble: valid_e, rd_valid_e, mem_read_e, mem_write_e and registered fwd_sel all 0; data fields (pc, rs data, imm, rd, alu_op) don't-care but SHALL also be zeroed.
REQ-011 SHALL treat flush and stall simultaneous as a single bubble; flush does not extend the stall.
REQ-012 SHALL load a normal instruction only when stall=0 and flush=0; valid_d=0 loads as a bubble (controls forced 0).
REQ-013 SHALL compute op_a_e combinationally: registered fwd bit0 -> alu_res_m, else bit2 -> reg_d_w, else registered rs1 data; M priority over W.
REQ-014 SHALL compute op_b_e identically from bits 1/3 and registered rs2 data.
REQ-015 SHALL never forward into a bubble: op_a_e/op_b_e equal zeroed registered data when valid_e=0.
REQ-016 SHALL make rd_e/rd_valid_e/mem_read_e available as the hazard unit's execute-side inputs with no combinational path from stall.
REQ-017 SHALL guarantee a stall never lasts more than one consecutive bubble for a single load (stall is driven externally; block holds no stall state).

Reset
REQ-018 SHALL, on rst_n=0 asynchronously, clear every register: all outputs 0, registered fwd_sel 0, counters 0.
REQ-019 SHALL resume normal loading on the first rising edge after rst_n deasserts; reset mid-stall discards the stall.

Configuration
REQ-020 SHALL, with HAZARD_STATS_EN defined, implement stall_cnt (+1 per edge with stall=1 and flush=0) and flush_cnt (+1 per edge with flush=1), both saturating at 32'hFFFF_FFFF.
REQ-021 SHALL, without HAZARD_STATS_EN, omit stall_cnt/flush_cnt ports and logic entirely; all other behaviour identical.

Verification
REQ-022 Load pc_d=0x100, rs1_data_d=5, rs2_data_d=7, fwd_sel=0, valid_d=1 -> next cycle pc_e=0x100, op_a_e=5, op_b_e=7, valid_e=1.
REQ-023 fwd_sel=4'b0101, alu_res_m=0xAA, reg_d_w=0xBB -> op_a_e=0xAA after edge (M wins); fwd_sel=4'b1000 -> op_b_e=0xBB.
REQ-024 stall=1 with mem_read_d=1, rd_valid_d=1 -> next cycle valid_e=0, mem_read_e=0, rd_valid_e=0, op_a_e=0 regardless of alu_res_m.
REQ-025 stall=1 and flush=1 same edge -> one bubble; with HAZARD_STATS_EN stall_cnt unchanged, flush_cnt +1.
REQ-026 rst_n low mid-stream between edges -> all outputs 0 immediately; first edge after release with valid_d=1 loads normally.
REQ-027 HAZARD_STATS_EN, stall_cnt preloaded near max via 2^32-1 stalls (or forced) -> stays 0xFFFF_FFFF on further stall.

Source files
------------

// File: rtl/decode_execute_reg.sv
// decode_execute_reg: ID/EX pipeline register with M/W operand forwarding.
// Define HAZARD_STATS_EN to add saturating stall_cnt/flush_cnt event counters.
module decode_execute_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_d,
   input  logic [31:0] pc_d,
   input  logic [31:0] rs1_data_d,
   input  logic [31:0] rs2_data_d,
   input  logic [31:0] imm_d,
   input  logic [4:0]  rd_d,
   input  logic        rd_valid_d,
   input  logic        mem_read_d,
   input  logic        mem_write_d,
   input  logic [3:0]  alu_op_d,
   input  logic [3:0]  fwd_sel,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] alu_res_m,
   input  logic [31:0] reg_d_w,
   output logic        valid_e,
   output logic        rd_valid_e,
   output logic        mem_read_e,
   output logic        mem_write_e,
   output logic [31:0] pc_e,
   output logic [31:0] imm_e,
   output logic [4:0]  rd_e,
   output logic [3:0]  alu_op_e,
   output logic [31:0] op_a_e,
`ifdef HAZARD_STATS_EN
   output logic [31:0] op_b_e,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`else
   output logic [31:0] op_b_e
`endif
);
   logic        load;
   logic        valid_e_d, rd_valid_e_d, mem_read_e_d, mem_write_e_d;
   logic        valid_e_q, rd_valid_e_q, mem_read_e_q, mem_write_e_q;
   logic [31:0] pc_e_d, imm_e_d, rs1_e_d, rs2_e_d;
   logic [31:0] pc_e_q, imm_e_q, rs1_e_q, rs2_e_q;
   logic [4:0]  rd_e_d, rd_e_q;
   logic [3:0]  alu_op_e_d, alu_op_e_q, fwd_e_d, fwd_e_q;

   // Anything other than a live, unstalled, unflushed instruction becomes an all-zero bubble.
   always_comb begin
      load          = valid_d & ~stall & ~flush;
      valid_e_d     = load;
      rd_valid_e_d  = load & rd_valid_d;
      mem_read_e_d  = load & mem_read_d;
      mem_write_e_d = load & mem_write_d;
      pc_e_d        = load ? pc_d       : 32'd0;
      imm_e_d       = load ? imm_d      : 32'd0;
      rs1_e_d       = load ? rs1_data_d : 32'd0;
      rs2_e_d       = load ? rs2_data_d : 32'd0;
      rd_e_d        = load ? rd_d       : 5'd0;
      alu_op_e_d    = load ? alu_op_d   : 4'd0;
      fwd_e_d       = load ? fwd_sel    : 4'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_e_q     <= 1'b0;
         rd_valid_e_q  <= 1'b0;
         mem_read_e_q  <= 1'b0;
         mem_write_e_q <= 1'b0;
         pc_e_q        <= 32'd0;
         imm_e_q       <= 32'd0;
         rs1_e_q       <= 32'd0;
         rs2_e_q       <= 32'd0;
         rd_e_q        <= 5'd0;
         alu_op_e_q    <= 4'd0;
         fwd_e_q       <= 4'd0;
      end else begin
         valid_e_q     <= valid_e_d;
         rd_valid_e_q  <= rd_valid_e_d;
         mem_read_e_q  <= mem_read_e_d;
         mem_write_e_q <= mem_write_e_d;
         pc_e_q        <= pc_e_d;
         imm_e_q       <= imm_e_d;
         rs1_e_q       <= rs1_e_d;
         rs2_e_q       <= rs2_e_d;
         rd_e_q        <= rd_e_d;
         alu_op_e_q    <= alu_op_e_d;
         fwd_e_q       <= fwd_e_d;
      end
   end

   // Memory-stage result has priority over writeback data.
   always_comb begin
      op_a_e = fwd_e_q[0] ? alu_res_m : fwd_e_q[2] ? reg_d_w : rs1_e_q;
      op_b_e = fwd_e_q[1] ? alu_res_m : fwd_e_q[3] ? reg_d_w : rs2_e_q;
   end

   assign valid_e     = valid_e_q;
   assign rd_valid_e  = rd_valid_e_q;
   assign mem_read_e  = mem_read_e_q;
   assign mem_write_e = mem_write_e_q;
   assign pc_e        = pc_e_q;
   assign imm_e       = imm_e_q;
   assign rd_e        = rd_e_q;
   assign alu_op_e    = alu_op_e_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

   // A flush swallows a coincident stall, so only unflushed stalls count.
   always_comb begin
      stall_cnt_d = (stall & ~flush & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (flush & ~&flush_cnt_q) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: randomized and directed checks of decode_execute_reg against a behavioural model.
module tb_decode_execute_reg;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_d = 1'b0;
   logic [31:0] pc_d = '0, rs1_data_d = '0, rs2_data_d = '0, imm_d = '0;
   logic [4:0]  rd_d = '0;
   logic        rd_valid_d = 1'b0, mem_read_d = 1'b0, mem_write_d = 1'b0;
   logic [3:0]  alu_op_d = '0, fwd_sel = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic [31:0] alu_res_m = '0, reg_d_w = '0;
   logic        valid_e, rd_valid_e, mem_read_e, mem_write_e;
   logic [31:0] pc_e, imm_e, op_a_e, op_b_e;
   logic [4:0]  rd_e;
   logic [3:0]  alu_op_e;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
   longint      m_scnt, m_fcnt;
`endif
   int          n_chk = 0, n_fail = 0;

   // Model of the instruction currently sitting in execute.
   bit          m_valid, m_rdv, m_mr, m_mw;
   logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
   logic [4:0]  m_rd;
   logic [3:0]  m_aop, m_fwd;

   decode_execute_reg dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .pc_d(pc_d),
      .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d),
      .rd_d(rd_d), .rd_valid_d(rd_valid_d), .mem_read_d(mem_read_d),
      .mem_write_d(mem_write_d), .alu_op_d(alu_op_d), .fwd_sel(fwd_sel),
      .stall(stall), .flush(flush), .alu_res_m(alu_res_m), .reg_d_w(reg_d_w),
      .valid_e(valid_e), .rd_valid_e(rd_valid_e), .mem_read_e(mem_read_e),
      .mem_write_e(mem_write_e), .pc_e(pc_e), .imm_e(imm_e), .rd_e(rd_e),
      .alu_op_e(alu_op_e), .op_a_e(op_a_e),
`ifdef HAZARD_STATS_EN
      .op_b_e(op_b_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
      .op_b_e(op_b_e)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      {m_valid, m_rdv, m_mr, m_mw} = '0;
      {m_pc, m_imm, m_rs1, m_rs2} = '0;
      m_rd = '0; m_aop = '0; m_fwd = '0;
`ifdef HAZARD_STATS_EN
      m_scnt = 0; m_fcnt = 0;
`endif
   endtask

   task automatic model_edge();
      bit take;
      take = valid_d && !stall && !flush;
      m_valid = take;
      m_rdv = take && rd_valid_d; m_mr = take && mem_read_d; m_mw = take && mem_write_d;
      m_pc  = take ? pc_d : 0;       m_imm = take ? imm_d : 0;
      m_rs1 = take ? rs1_data_d : 0; m_rs2 = take ? rs2_data_d : 0;
      m_rd  = take ? rd_d : 0;       m_aop = take ? alu_op_d : 0;
      m_fwd = take ? fwd_sel : 0;
`ifdef HAZARD_STATS_EN
      if (stall && !flush && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (flush && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
`endif
   endtask

   function automatic logic [31:0] exp_op(input logic [31:0] reg_val, input bit from_m, input bit from_w);
      if (!m_valid) return 32'd0;
      if (from_m) return alu_res_m;
      if (from_w) return reg_d_w;
      return reg_val;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, {31'd0, valid_e}, {31'd0, m_valid});
      chk({tag, ".rdv"}, {31'd0, rd_valid_e}, {31'd0, m_rdv});
      chk({tag, ".mr"}, {31'd0, mem_read_e}, {31'd0, m_mr});
      chk({tag, ".mw"}, {31'd0, mem_write_e}, {31'd0, m_mw});
      chk({tag, ".pc"}, pc_e, m_pc);
      chk({tag, ".imm"}, imm_e, m_imm);
      chk({tag, ".rd"}, {27'd0, rd_e}, {27'd0, m_rd});
      chk({tag, ".aop"}, {28'd0, alu_op_e}, {28'd0, m_aop});
      chk({tag, ".op_a"}, op_a_e, exp_op(m_rs1, m_fwd[0], m_fwd[2]));
      chk({tag, ".op_b"}, op_b_e, exp_op(m_rs2, m_fwd[1], m_fwd[3]));
`ifdef HAZARD_STATS_EN
      chk({tag, ".scnt"}, stall_cnt, m_scnt[31:0]);
      chk({tag, ".fcnt"}, flush_cnt, m_fcnt[31:0]);
`endif
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive_random();
      valid_d = ($urandom_range(0, 9) < 8);
      pc_d = $urandom; rs1_data_d = $urandom; rs2_data_d = $urandom; imm_d = $urandom;
      rd_d = 5'($urandom); rd_valid_d = 1'($urandom); mem_read_d = 1'($urandom);
      mem_write_d = 1'($urandom); alu_op_d = 4'($urandom); fwd_sel = 4'($urandom);
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 6) == 0);
      alu_res_m = $urandom; reg_d_w = $urandom;
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      valid_d = 1; pc_d = pc; rs1_data_d = a; rs2_data_d = b; fwd_sel = f;
      stall = 0; flush = 0;
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      drive_instr(32'h100, 32'd5, 32'd7, 4'b0000);
      step("load");
      chk("load.pc_lit", pc_e, 32'h100);
      chk("load.a_lit", op_a_e, 32'd5);
      chk("load.b_lit", op_b_e, 32'd7);

      drive_instr(32'h104, 32'd1, 32'd2, 4'b0101);
      alu_res_m = 32'hAA; reg_d_w = 32'hBB;
      step("fwd_mw");
      chk("fwd_mw.a_lit", op_a_e, 32'hAA);
      drive_instr(32'h108, 32'd1, 32'd2, 4'b1000);
      step("fwd_w");
      chk("fwd_w.b_lit", op_b_e, 32'hBB);

      drive_instr(32'h10C, 32'd9, 32'd9, 4'b1111);
      mem_read_d = 1; rd_valid_d = 1; stall = 1; alu_res_m = 32'hDEAD_BEEF;
      step("stall");
      chk("stall.a_lit", op_a_e, 32'd0);
      stall = 1; flush = 1;
      step("stall_flush");
      stall = 0; flush = 0;
      step("after_bubble");

      // Outputs must not react combinationally to new decode/stall inputs.
      for (int i = 0; i < 300; i++) begin
         drive_random();
         #1;
         check_all("hold");
         step("rnd");
      end

      drive_instr(32'h300, 32'd3, 32'd4, 4'b0000);
      step("pre_arst");
      #2;
      stall = 1; rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk);
      rst_n = 1'b1;
      drive_instr(32'h200, 32'd11, 32'd12, 4'b0000);
      step("post_arst");
      chk("post_arst.pc_lit", pc_e, 32'h200);

`ifdef HAZARD_STATS_EN
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.stall_cnt_q;
      m_scnt = 64'hFFFF_FFFE;
      stall = 1; flush = 0;
      repeat (3) step("sat");
      chk("sat.lit", stall_cnt, 32'hFFFF_FFFF);
      stall = 0;
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
